// File: rtl/sample_mem_loader_if.sv
// ---------------------------------------------------------------------------
// sample_mem_loader_if
//   Bundles the load request, the incoming sample stream and the sample-RAM
//   write port of the sample buffer loader.
//
//   Parameters
//     DW  sample width (two's complement)
//     AW  RAM address width
//
//   Signals
//     do_load       level request; 1 = load/hold, 0 = abort/idle
//     sample_in     signed sample, qualified by sample_valid
//     sample_valid  one-cycle strobe per sample
//     addr          RAM write address
//     data_out      RAM write data (signed)
//     we            RAM write enable, one cycle per write
//     busy          high while the buffer is being filled
//     mem_loaded    high once DEPTH fresh samples have been written
//
//   Modports
//     master  sample source / controller side
//     slave   loader side
// ---------------------------------------------------------------------------
interface sample_mem_loader_if #(
  parameter int DW = 10,
  parameter int AW = 11
);
  logic                 do_load;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic        [AW-1:0] addr;
  logic signed [DW-1:0] data_out;
  logic                 we;
  logic                 busy;
  logic                 mem_loaded;

  modport master (
    output do_load, sample_in, sample_valid,
    input  addr, data_out, we, busy, mem_loaded
  );

  modport slave (
    input  do_load, sample_in, sample_valid,
    output addr, data_out, we, busy, mem_loaded
  );
endinterface

// File: rtl/sample_mem_loader.sv
// ---------------------------------------------------------------------------
// sample_mem_loader
//   Fills the signed sample buffer with DEPTH sequential writes taken from
//   the incoming sample stream. While do_load is held high the loader moves
//   IDLE -> FILL -> DONE; dropping do_load returns it to IDLE from any state
//   and leaves whatever was written in place. All outputs are registered.
//
//   Optional feature (macro LOAD_DECIM_EN):
//     When defined, only the first strobe and every DECIM-th strobe after it
//     are written; DEPTH writes are still required to finish.
//     When undefined, every valid strobe is written and DECIM is unused.
//
//   Parameters
//     DEPTH  words written per load (address width = $clog2(DEPTH))
//     DW     sample width
//     DECIM  decimation ratio, 1..255 (LOAD_DECIM_EN only)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    sample_mem_loader_if.slave (request, stream in, RAM write out)
// ---------------------------------------------------------------------------
module sample_mem_loader #(
  parameter int DEPTH = 2048,
  parameter int DW    = 10,
  parameter int DECIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sample_mem_loader_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic        [AW-1:0] r_idx;
  logic        [AW-1:0] r_addr;
  logic signed [DW-1:0] r_data;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_loaded;

  logic                 w_strobe;   // qualified strobe inside an active fill
  logic                 w_keep;     // this strobe is selected for writing
  logic                 w_wr;       // a RAM write is issued on this edge
  logic        [AW-1:0] w_addr_nxt;
  logic signed [DW-1:0] w_data_nxt;
  logic                 w_busy_nxt;
  logic                 w_loaded_nxt;

  // Strobes only count in FILL while the request is still up; a strobe in
  // the cycle that do_load drops is discarded.
  assign w_strobe = (r_state == S_FILL) && bus.do_load && bus.sample_valid;
  assign w_wr     = w_strobe && w_keep;

`ifdef LOAD_DECIM_EN
  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  logic [7:0] r_dcnt;

  assign w_keep = (r_dcnt == 8'd0);

  // Mod-DECIM strobe counter, cleared whenever the loader is not filling so
  // that every load starts by writing its first strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= 8'd0;
    end else if (r_state != S_FILL || !bus.do_load) begin
      r_dcnt <= 8'd0;
    end else if (w_strobe) begin
      r_dcnt <= (r_dcnt == DECIM_LAST) ? 8'd0 : r_dcnt + 8'd1;
    end
  end
`else
  assign w_keep = 1'b1;
`endif

  // State register and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_we     <= w_wr;
      r_busy   <= w_busy_nxt;
      r_loaded <= w_loaded_nxt;
      // The index restarts at 0 on every entry into FILL and stops at the
      // last address instead of wrapping.
      if (w_state_nxt != S_FILL) begin
        r_idx <= '0;
      end else if (w_wr && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Next-state logic. do_load low overrides everything.
  always_comb begin
    // NOTE: default assignment first keeps this combinational block free of
    // inferred latches on paths that do not assign it.
    w_state_nxt = r_state;
    if (!bus.do_load) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_nxt = S_FILL;
        S_FILL:  if (w_wr && r_idx == LAST_IDX) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: values the output registers take on the next edge.
  // addr/data_out hold their last write when no write is issued.
  always_comb begin
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_busy_nxt   = (w_state_nxt == S_FILL);
    w_loaded_nxt = (w_state_nxt == S_DONE);
    if (w_wr) begin
      w_addr_nxt = r_idx;
      w_data_nxt = bus.sample_in;
    end
  end

  assign bus.addr       = r_addr;
  assign bus.data_out   = r_data;
  assign bus.we         = r_we;
  assign bus.busy       = r_busy;
  assign bus.mem_loaded = r_loaded;

endmodule
